// File: rtl/remainder_scheduler.sv
// -----------------------------------------------------------------------------
// remainder_scheduler
//
// Four-requester round-robin front end feeding a bit-serial "mod 3" engine.
// While idle, the next requester with a pending word is granted, starting the
// search at ptr. The granted word is shifted in MSB first, one bit per cycle,
// through a 3-state remainder automaton. The remainder is then presented with
// a valid/ready handshake.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   req        [3:0]         per-requester pending flag
//   req_data   [4*WIDTH-1:0] requester i word on bits [i*WIDTH +: WIDTH]
//   gnt        [3:0]         one-hot, combinational; high in the capture cycle
//   out_valid  result available (DONE state)
//   out_ready  consumer accepts the result
//   out_rem    [1:0]         captured word mod 3
//   out_id     [1:0]         requester that supplied the word
//   busy       high while in SHIFT or DONE
// -----------------------------------------------------------------------------
module remainder_scheduler #(
   parameter int WIDTH = 8   // operand width, 2..32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           req,
   input  logic [4*WIDTH-1:0]   req_data,
   output logic [3:0]           gnt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           out_rem,
   output logic [1:0]           out_id,
   output logic                 busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [1:0]       ptr;
   logic [1:0]       acc;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sreg;

   logic             sel_found;
   logic [1:0]       sel_id;
   logic [1:0]       probe;

   // One step of the mod-3 automaton: next = (2*acc + bit) mod 3.
   // The unreachable encoding 3 falls back to 0 so a corrupted accumulator
   // heals on the next shift.
   function automatic logic [1:0] acc_step(input logic [1:0] a, input logic b);
      case (a)
         2'd0:    acc_step = b ? 2'd1 : 2'd0;
         2'd1:    acc_step = b ? 2'd0 : 2'd2;
         2'd2:    acc_step = b ? 2'd2 : 2'd1;
         default: acc_step = 2'd0;
      endcase
   endfunction

   // Round-robin pick: first set req bit at or after ptr, wrapping 3->0.
   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = ptr;
      probe     = ptr;
      for (int k = 0; k < 4; k++) begin
         probe = ptr + 2'(k);
         if (!sel_found && req[probe]) begin
            sel_found = 1'b1;
            sel_id    = probe;
         end
      end
   end

   // Next-state and grant. gnt is also gated by rst so reset holds it low
   // even though it is combinational.
   always_comb begin
      state_next = state;
      gnt        = 4'b0000;
      case (state)
         IDLE: begin
            if (sel_found && !rst) begin
               gnt        = 4'b0001 << sel_id;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == CW'(WIDTH - 1))
               state_next = DONE;
         end
         DONE: begin
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ptr    <= 2'd0;
         acc    <= 2'd0;
         cnt    <= '0;
         out_id <= 2'd0;
         sreg   <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (state_next == SHIFT) begin
                  // req_data is sampled only here, in the grant cycle.
                  sreg   <= req_data[sel_id*WIDTH +: WIDTH];
                  acc    <= 2'd0;
                  cnt    <= '0;
                  out_id <= sel_id;
               end
            end
            SHIFT: begin
               acc  <= acc_step(acc, sreg[WIDTH-1]);
               sreg <= {sreg[WIDTH-2:0], 1'b0};
               cnt  <= cnt + CW'(1);
            end
            DONE: begin
               if (out_ready)
                  ptr <= out_id + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (state == DONE);
   assign busy      = (state == SHIFT) || (state == DONE);
   assign out_rem   = acc;

endmodule

// File: tb/tb_remainder_scheduler.sv
// -----------------------------------------------------------------------------
// tb_remainder_scheduler
//
// Directed bench for remainder_scheduler with WIDTH=8. Inputs change 1 ns after
// a rising edge; registered outputs are sampled there, and the combinational
// gnt 1 ns later.
// -----------------------------------------------------------------------------
module tb_remainder_scheduler;

   localparam int WIDTH = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [3:0]         req;
   logic [4*WIDTH-1:0] req_data;
   logic [3:0]         gnt;
   logic               out_valid;
   logic               out_ready;
   logic [1:0]         out_rem;
   logic [1:0]         out_id;
   logic               busy;

   int n_checks = 0;
   int n_fail   = 0;

   remainder_scheduler #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_rem   (out_rem),
      .out_id    (out_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;   // {d3, d2, d1, d0}
      logic [3:0]  gnt;
      logic [1:0]  rem;
      logic [1:0]  id;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called 1 ns after an edge with the block idle and inputs already set.
   // Expects a grant now, a result WIDTH+1 cycles later, and an immediate
   // handshake (out_ready must be 1).
   task automatic run_op(input string name, input logic [3:0] eg,
                         input logic [1:0] er, input logic [1:0] eid);
      int n;
      #1;
      check({name, "_gnt"}, 32'(gnt), 32'(eg));
      @(posedge clk); #1;
      req = 4'b0000;
      check({name, "_busy"}, 32'(busy), 32'd1);
      n = 1;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_latency"}, 32'(n), 32'(WIDTH + 1));
      check({name, "_rem"}, 32'(out_rem), 32'(er));
      check({name, "_id"}, 32'(out_id), 32'(eid));
      @(posedge clk); #1;
      check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gcount, last, n, hs;
      int order[5];

      // Pointer walk (values in comments are ptr before each vector).
      vecs[0] = '{4'b0001, {8'd0,   8'd0,   8'd0, 8'd100}, 4'b0001, 2'd1, 2'd0}; // ptr0
      vecs[1] = '{4'b0001, {8'd0,   8'd0,   8'd0, 8'd0  }, 4'b0001, 2'd0, 2'd0}; // ptr1, wraps
      vecs[2] = '{4'b0011, {8'd0,   8'd0,   8'd5, 8'd255}, 4'b0010, 2'd2, 2'd1}; // ptr1
      vecs[3] = '{4'b1001, {8'd255, 8'd0,   8'd0, 8'd128}, 4'b1000, 2'd0, 2'd3}; // ptr2
      vecs[4] = '{4'b1001, {8'd7,   8'd0,   8'd0, 8'd128}, 4'b0001, 2'd2, 2'd0}; // ptr0
      vecs[5] = '{4'b0100, {8'd0,   8'd255, 8'd0, 8'd0  }, 4'b0100, 2'd0, 2'd2}; // ptr1
      vecs[6] = '{4'b0001, {8'd0,   8'd0,   8'd0, 8'd5  }, 4'b0001, 2'd2, 2'd0}; // ptr3, wraps

      // Reset state, with requests pending to show gnt is held low.
      rst = 1'b1; req = 4'b1111; req_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      rst = 1'b0; req = 4'b0000;
      @(posedge clk); #1;
      check("idle_noreq_gnt", 32'(gnt), 32'd0);
      check("idle_noreq_busy", 32'(busy), 32'd0);

      // Table-driven single operations.
      for (int i = 0; i < 7; i++) begin
         req_data = vecs[i].data;
         req      = vecs[i].req;
         run_op($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].rem, vecs[i].id);
      end

      // Round robin with all requests held: order 0,1,2,3,0 spaced WIDTH+2.
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      order = '{0, 1, 2, 3, 0};
      req_data = {8'd10, 8'd11, 8'd12, 8'd13};
      req = 4'b1111;
      gcount = 0; last = 0;
      for (int c = 0; c < 80 && gcount < 5; c++) begin
         #1;
         if (gnt != 4'b0000) begin
            check($sformatf("rr_gnt%0d", gcount), 32'(gnt), 32'(4'b0001 << order[gcount]));
            if (gcount > 0)
               check($sformatf("rr_spacing%0d", gcount), 32'(c - last), 32'(WIDTH + 2));
            last = c;
            gcount++;
         end
         @(posedge clk); #1;
      end
      check("rr_grant_count", 32'(gcount), 32'd5);
      req = 4'b0000;
      n = 0;
      while ((busy || out_valid) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("rr_drain_timeout", 32'(n < 40), 32'd1);

      // Backpressure: requester 1 (ptr is 1 after id 0 completed), 200 mod 3 = 2.
      req_data = {8'd0, 8'd0, 8'd200, 8'd0};
      req = 4'b0010; out_ready = 1'b0;
      #1;
      check("bp_gnt", 32'(gnt), 32'(4'b0010));
      @(posedge clk); #1;
      n = 1;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_latency", 32'(n), 32'(WIDTH + 1));
      // Request stays high during the stall: no new grant may appear.
      for (int c = 0; c < 20; c++) begin
         #1;
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_rem", 32'(out_rem), 32'd2);
         check("bp_id", 32'(out_id), 32'd1);
         check("bp_gnt_hold", 32'(gnt), 32'd0);
         @(posedge clk); #1;
      end
      req = 4'b0000; out_ready = 1'b1;
      hs = 0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid && out_ready) hs++;
         @(posedge clk); #1;
      end
      check("bp_single_completion", 32'(hs), 32'd1);
      check("bp_idle_busy", 32'(busy), 32'd0);

      // Reset mid-SHIFT (ptr is 2 here, so requester 3 wins).
      req_data = {8'd9, 8'd0, 8'd17, 8'd0};
      req = 4'b1000;
      #1;
      check("mid_gnt", 32'(gnt), 32'(4'b1000));
      @(posedge clk); #1;
      req = 4'b0000;
      repeat (3) @(posedge clk);
      #1;                                  // now in cycle G+4
      rst = 1'b1; req = 4'b0110;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_gnt", 32'(gnt), 32'd0);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         check("mid_rst_no_result", 32'(out_valid), 32'd0);
      end
      rst = 1'b0;
      // ptr restarts at 0, so bit 1 beats bit 2 (17 mod 3 = 2).
      run_op("post_rst", 4'b0010, 2'd2, 2'd1);

      // Exhaustive 8-bit sweep from requester 0.
      for (int v = 0; v < 256; v++) begin
         req_data = {24'd0, 8'(v)};
         req = 4'b0001;
         run_op($sformatf("exh%0d", v), 4'b0001, 2'(v % 3), 2'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/remainder_scheduler.md
REMAINDER_SCHEDULER -- requirements
Module: remainder_scheduler

Interface
REQ-001 Parameter WIDTH, default 8, meaning operand width in bits; legal range 2..32.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  per-requester request; bit i means requester i has a word pending.
REQ-005 req_data  input  4*WIDTH  requester i word on bits [i*WIDTH +: WIDTH].
REQ-006 gnt  output  4  one-hot acceptance; combinational, high only in the cycle the word is captured.
REQ-007 out_valid  output  1  result available.
REQ-008 out_ready  input  1  consumer accepts result.
REQ-009 out_rem  output  2  word mod 3; value 0..2.
REQ-010 out_id  output  2  index of the requester whose word produced out_rem.
REQ-011 busy  output  1  high in SHIFT and DONE states.

Function
REQ-012 The block SHALL implement three states: IDLE, SHIFT, DONE.
REQ-013 In IDLE with req != 0, the block SHALL assert exactly one gnt bit, choosing round-robin: first set req bit at or after pointer ptr, wrapping 3->0.
REQ-014 On that edge the block SHALL capture the granted word into a shift register, clear the remainder accumulator to 0, clear the bit counter, record out_id, and enter SHIFT.
REQ-015 In IDLE with req == 0, gnt SHALL be 0 and state SHALL stay IDLE.
REQ-016 In SHIFT, each cycle SHALL consume the shift register MSB and set acc <= (2*acc + bit) mod 3, using transitions 0:{0->0,1->1}, 1:{0->2,1->0}, 2:{0->1,1->2}.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, then enter DONE.
REQ-018 In DONE, out_valid SHALL be 1, with out_rem and out_id stable until handshake.
REQ-019 out_valid SHALL be 0 in IDLE and SHIFT; out_rem and out_id are don't-care when out_valid is 0.
REQ-020 A DONE cycle with out_ready high SHALL complete the handshake, set ptr <= out_id+1 (mod 4), and enter IDLE.
REQ-021 With out_ready low, DONE SHALL hold indefinitely, with no gnt asserted.
REQ-022 Latency: gnt in cycle G; out_valid first high in cycle G+WIDTH+1; minimum spacing between grants is WIDTH+2 cycles.
REQ-023 Requests arriving or changing during SHIFT/DONE SHALL be ignored until IDLE; req_data SHALL be sampled only in the gnt cycle.
REQ-024 A requester dropping req before grant SHALL be skipped without side effects.
REQ-025 A requester SHALL be able to deassert req the cycle after its gnt; holding req keeps it eligible for a later round.
REQ-026 The accumulator SHALL never hold value 3; an illegal state SHALL recover to 0 on the next SHIFT step.

Reset
REQ-027 While rst is high, the block SHALL force: state=IDLE, ptr=0, acc=0, counter=0, out_id=0, out_valid=0, busy=0, gnt=0.
REQ-028 Reset asserted mid-SHIFT or mid-DONE SHALL abort the operation with no result emitted; after release, arbitration restarts from ptr=0.

Verification
REQ-029 Single request, WIDTH=8: req=0001, data0=8'd100, out_ready=1 -> gnt=0001 at G; out_valid at G+9 with out_rem=1, out_id=0.
REQ-030 Value sweep: words 8'd0, 8'd255, 8'd5, 8'd128 -> out_rem 0, 0, 2, 2 respectively.
REQ-031 Round-robin: req=1111 held, out_ready=1 -> grant order 0,1,2,3,0; grants spaced 10 cycles apart.
REQ-032 Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid, out_rem and out_id stable; gnt=0; single completion when out_ready rises.
REQ-033 Reset mid-operation: assert rst at G+4 -> out_valid stays 0, busy=0; after release with req=0100, gnt=0100 follows.
REQ-034 Exhaustive check: all 256 values for WIDTH=8 -> out_rem matches value mod 3 for every word.
